// File: rtl/out_collector.sv
// Gathers strobed samples from many core channels into one FWFT FIFO.
// Each core owns a one-deep hold slot; a round-robin arbiter drains the slots.
module out_collector #(
   parameter int NCORES = 43,
   parameter int DW     = 31,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NCORES*DW-1:0]     core_data,
   input  logic [NCORES*4-1:0]      core_en,
   output logic signed [DW-1:0]     m_data,
   output logic [5:0]               m_core,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [15:0]              drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = 6;
   localparam int EW = CW + DW;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(NCORES - 1);

   logic [DW-1:0]     hold_q [NCORES];
   logic [NCORES-1:0] pend_q, pend_d;
   logic [NCORES-1:0] stb, drain, dropv, capt;
   logic [CW-1:0]     start_q, start_d;
   logic [CW-1:0]     gnt_idx;
   logic              gnt_vld;
   logic              push, pop, space;

   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     head;
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       cnt_q, cnt_d;

   logic              ovf_q, ovf_d;
   logic [15:0]       drop_q, drop_d;
   logic [CW:0]       ndrop;
   logic [16:0]       dsum;

   always_comb begin
      for (int i = 0; i < NCORES; i++) begin
         stb[i] = (core_en[i*4 +: 4] == 4'd1);
      end
   end

   // Search order begins one past the last granted core.
   always_comb begin
      int idx;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NCORES; k++) begin
         idx = int'(start_q) + k;
         if (idx >= NCORES) idx = idx - NCORES;
         if (!gnt_vld && pend_q[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = CW'(idx);
         end
      end
   end

   assign m_valid = (cnt_q != '0);
   assign pop     = m_valid && m_ready;
   assign space   = (cnt_q != FULL) || pop;
   assign push    = gnt_vld && space;

   always_comb begin
      ndrop = '0;
      for (int i = 0; i < NCORES; i++) begin
         drain[i]  = push && (gnt_idx == CW'(i));
         dropv[i]  = stb[i] && pend_q[i] && !drain[i];
         capt[i]   = stb[i] && !dropv[i];
         pend_d[i] = capt[i] | (pend_q[i] & ~drain[i]);
         ndrop     = ndrop + (CW+1)'(dropv[i]);
      end
   end

   always_comb begin
      start_d = start_q;
      if (push) begin
         start_d = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_comb begin
      dsum   = {1'b0, drop_q} + 17'(ndrop);
      drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];
      ovf_d  = ovf_q | (ndrop != '0);
   end

   always_comb begin
      wptr_d = wptr_q + AW'(push);
      rptr_d = rptr_q + AW'(pop);
      cnt_d  = cnt_q;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   // Sample storage needs no reset; validity lives in pend_q and cnt_q.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NCORES; i++) begin
         if (capt[i]) hold_q[i] <= core_data[i*DW +: DW];
      end
      if (push) mem_q[wptr_q] <= {gnt_idx, hold_q[gnt_idx]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q  <= '0;
         start_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         pend_q  <= pend_d;
         start_q <= start_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   assign head       = mem_q[rptr_q];
   assign m_data     = m_valid ? head[DW-1:0] : '0;
   assign m_core     = m_valid ? head[EW-1:DW] : '0;
   assign fifo_count = cnt_q;
   assign overflow   = ovf_q;
   assign drop_count = drop_q;

endmodule

// File: doc/out_collector.md
OUT_COLLECTOR -- requirements
Module: out_collector

Interface
REQ-001 Parameter NCORES, default 43, number of core output channels.
REQ-002 Parameter DW, default 31, signed sample width.
REQ-003 Parameter DEPTH, default 16, output FIFO depth (power of 2, >=2).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 core_data  in  NCORES*DW  packed io_out buses; core i at bits [i*DW +: DW].
REQ-007 core_en  in  NCORES*4  packed out_en fields; core i at bits [i*4 +: 4].
REQ-008 m_data  out  DW  signed sample at FIFO head.
REQ-009 m_core  out  6  core index of head sample.
REQ-010 m_valid  out  1  head entry valid.
REQ-011 m_ready  in  1  consumer accepts head.
REQ-012 fifo_count  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  out  1  sticky: at least one sample dropped since reset.
REQ-014 drop_count  out  16  dropped-sample counter, saturating.

Function
REQ-015 Strobe for core i is core_en field == 4'd1 exactly; any other value is no strobe.
REQ-016 Each core has a one-entry hold register (data + pending flag); strobe captures core_data slice at that edge, pending=1.
REQ-017 Strobe while pending=1 and not drained same edge: new sample dropped, held sample kept, overflow=1, drop_count+1.
REQ-018 Strobe on same edge the core's held sample is drained: new sample captured, pending stays 1, no drop.
REQ-019 Multiple cores strobing same edge: all captured independently.
REQ-020 Round-robin arbiter grants at most one pending core per edge; search starts at (last_grant+1) mod NCORES; after reset search starts at core 0.
REQ-021 Grant only when FIFO can accept: fifo_count<DEPTH, or fifo_count==DEPTH and a pop occurs same edge.
REQ-022 Granted entry {core index, data} pushed to FIFO at grant edge; core's pending cleared unless REQ-018 applies.
REQ-023 FIFO is first-word-fall-through; m_valid = (fifo_count!=0); m_data/m_core reflect head combinationally from storage.
REQ-024 Pop when m_valid && m_ready at rising edge; m_ready while m_valid=0 ignored.
REQ-025 Simultaneous push and pop: fifo_count unchanged, order preserved.
REQ-026 Latency: strobe at edge k -> pending after k -> pushed at edge k+1 (if granted) -> m_valid high after edge k+1 when FIFO empty; minimum 2 edges.
REQ-027 Read/write pointers wrap modulo DEPTH.
REQ-028 drop_count saturates at 16'hFFFF; overflow never clears except by reset.
REQ-029 m_data unchanged while m_valid=1 and m_ready=0 (stable head).

Reset
REQ-030 rst=1 asynchronously clears all pending flags, FIFO pointers, fifo_count=0, m_valid=0, overflow=0, drop_count=0, last_grant so next search starts at core 0.
REQ-031 m_data and m_core SHALL read 0 during reset; hold-register data contents need not be cleared.
REQ-032 Reset asserted mid-transfer discards all pending and queued samples; first strobe after deassertion behaves per REQ-026.

Verification
REQ-033 Single strobe: core 5 en=1, data=-1234, m_ready=1 -> after 2 edges m_valid=1, m_data=-1234, m_core=5, popped next edge, fifo_count returns 0.
REQ-034 Fairness: cores 0,7,42 strobe same edge -> outputs in order 0,7,42 on three consecutive cycles; next simultaneous burst of 0 and 42 after last_grant=42 -> order 0,42.
REQ-035 Backpressure: m_ready=0, 20 single-core strobes spread over 20 cores -> fifo_count reaches 16, 4 held pending, no drops; release m_ready -> all 20 delivered, none lost.
REQ-036 Overflow: m_ready=0, FIFO full, core 3 strobes twice -> second dropped, overflow=1, drop_count=1, first value delivered later.
REQ-037 Non-strobe codes: core 2 en=4'd2, 4'd3, 4'd15 -> no capture, fifo_count stays 0.
REQ-038 Reset mid-operation: FIFO holding 8 entries, rst pulsed asynchronously between edges -> m_valid=0, fifo_count=0, overflow=0 immediately.
